// File: rtl/drive_cmd_pkg.sv
// Shared types and byte codes for the drive command arbiter.
// Direction vectors are one-hot, W at bit 0 through STOP at bit 8.
package drive_cmd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MANUAL,
    S_AUTO,
    S_ESTOP
  } state_e;

  localparam int unsigned D_W    = 0;
  localparam int unsigned D_A    = 1;
  localparam int unsigned D_S    = 2;
  localparam int unsigned D_D    = 3;
  localparam int unsigned D_WA   = 4;
  localparam int unsigned D_WD   = 5;
  localparam int unsigned D_AS   = 6;
  localparam int unsigned D_AD   = 7;
  localparam int unsigned D_STOP = 8;

  localparam logic [8:0] DIR_STOP = 9'b1 << D_STOP;

  localparam logic [7:0] B_MAN   = 8'h4D;
  localparam logic [7:0] B_AUTO  = 8'h41;
  localparam logic [7:0] B_IDLE  = 8'h49;
  localparam logic [7:0] B_ESTOP = 8'h21;
  localparam logic [7:0] B_REL   = 8'h52;
  localparam logic [7:0] B_W     = 8'h77;
  localparam logic [7:0] B_A     = 8'h61;
  localparam logic [7:0] B_S     = 8'h73;
  localparam logic [7:0] B_D     = 8'h64;
  localparam logic [7:0] B_WA    = 8'h71;
  localparam logic [7:0] B_WD    = 8'h65;
  localparam logic [7:0] B_AS    = 8'h7A;
  localparam logic [7:0] B_AD    = 8'h63;
  localparam logic [7:0] B_X     = 8'h78;

  typedef struct packed {
    logic       legal;
    logic       is_dir;
    logic [8:0] dir;
  } byte_dec_t;

  function automatic byte_dec_t decode_byte(
    input logic [7:0] b
  );
    byte_dec_t r;
    r.legal  = 1'b1;
    r.is_dir = 1'b1;
    r.dir    = DIR_STOP;
    case (b)
      B_W:  r.dir = 9'b1 << D_W;
      B_A:  r.dir = 9'b1 << D_A;
      B_S:  r.dir = 9'b1 << D_S;
      B_D:  r.dir = 9'b1 << D_D;
      B_WA: r.dir = 9'b1 << D_WA;
      B_WD: r.dir = 9'b1 << D_WD;
      B_AS: r.dir = 9'b1 << D_AS;
      B_AD: r.dir = 9'b1 << D_AD;
      B_X:  r.dir = DIR_STOP;
      B_MAN, B_AUTO, B_IDLE,
      B_ESTOP, B_REL: r.is_dir = 1'b0;
      default: begin
        r.legal  = 1'b0;
        r.is_dir = 1'b0;
      end
    endcase
    return r;
  endfunction

  function automatic logic is_onehot(
    input logic [8:0] v
  );
    return (v != 9'd0) &&
           ((v & (v - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Saturating inactivity counter for the drive arbiter.
// hit_o pulses on the update that reaches the limit; expired_o holds.
module cmd_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic active_i,
  input  logic kick_i,
  input  logic clear_i,
  output logic hit_o,
  output logic expired_o
);

  localparam int unsigned CW =
    $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX =
    CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          exp_q;
  logic          exp_d;

  always_comb begin
    cnt_d = cnt_q;
    exp_d = exp_q;
    if (clear_i || kick_i || !active_i) begin
      cnt_d = '0;
      exp_d = 1'b0;
    end else if (cnt_q != MAX) begin
      cnt_d = cnt_q + CW'(1);
      exp_d = (cnt_d == MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign hit_o     = exp_d && !exp_q;
  assign expired_o = exp_q;

endmodule

// File: rtl/drive_command_arbiter.sv
// Mode FSM and drive-direction arbiter between the Arduino command
// link and the autonomous decision tree, with watchdog and e-stop.
module drive_command_arbiter
  import drive_cmd_pkg::*;
#(
  parameter int unsigned CMD_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned CONFIRM_COUNT  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             auto_valid,
  input  logic [8:0]       auto_dir,
  output logic [8:0]       dir,
  output logic             manual_on,
  output logic             auto_on,
  output logic             estop,
  output logic             timeout_flag,
  output logic             cmd_error
);

  localparam logic [CMD_W-1:0] LOW_MASK =
    CMD_W'(8'hFF);
  localparam logic [3:0] CONF =
    4'(CONFIRM_COUNT);

  state_e     state_q;
  state_e     state_d;
  logic [8:0] dir_q;
  logic [8:0] dir_d;
  logic [8:0] pend_q;
  logic [8:0] pend_d;
  logic [3:0] ccnt_q;
  logic [3:0] ccnt_d;
  logic       err_q;
  logic       err_d;

  byte_dec_t  dec;
  logic [7:0] b;
  logic       legal;
  logic       illegal;
  logic       is_mode;
  logic       chg;
  logic       auto_take;
  logic       auto_ok;
  logic       auto_bad;
  logic       man_dir;
  logic       kick;
  logic       apply;
  logic       wd_active;
  logic       wd_hit;
  logic       wd_expired;

  assign b   = cmd_data[7:0];
  assign dec = decode_byte(b);

  assign legal = cmd_valid && dec.legal &&
    ((cmd_data & ~LOW_MASK) == '0);
  assign illegal = cmd_valid && !legal;
  assign is_mode = legal && !dec.is_dir;

  always_comb begin
    state_d = state_q;
    if (is_mode && b == B_ESTOP) begin
      state_d = S_ESTOP;
    end else if (is_mode) begin
      unique case (state_q)
        S_IDLE: begin
          if (b == B_MAN)
            state_d = S_MANUAL;
          else if (b == B_AUTO)
            state_d = S_AUTO;
        end
        S_MANUAL: begin
          if (b == B_AUTO)
            state_d = S_AUTO;
          else if (b == B_IDLE)
            state_d = S_IDLE;
        end
        S_AUTO: begin
          if (b == B_MAN)
            state_d = S_MANUAL;
          else if (b == B_IDLE)
            state_d = S_IDLE;
        end
        S_ESTOP: begin
          if (b == B_REL)
            state_d = S_IDLE;
        end
      endcase
    end
  end

  assign chg = (state_d != state_q);

  // a mode byte in the same cycle discards the auto sample
  assign auto_take = (state_q == S_AUTO) &&
    auto_valid && !is_mode;
  assign auto_ok  = auto_take && is_onehot(auto_dir);
  assign auto_bad = auto_take && !auto_ok;

  assign man_dir = (state_q == S_MANUAL) &&
    legal && dec.is_dir;
  assign kick = man_dir || auto_ok;
  assign wd_active = (state_q == S_MANUAL) ||
    (state_q == S_AUTO);

  always_comb begin
    pend_d = pend_q;
    ccnt_d = ccnt_q;
    apply  = 1'b0;
    if (chg) begin
      ccnt_d = '0;
    end else if (man_dir) begin
      if (dec.dir == pend_q) begin
        if (ccnt_q < CONF)
          ccnt_d = ccnt_q + 4'd1;
      end else begin
        pend_d = dec.dir;
        ccnt_d = 4'd1;
      end
      apply = (ccnt_d == CONF);
    end
  end

  always_comb begin
    dir_d = dir_q;
    if (chg || !wd_active)
      dir_d = DIR_STOP;
    else if (apply)
      dir_d = dec.dir;
    else if (auto_ok)
      dir_d = auto_dir;
    else if (auto_bad || wd_hit)
      dir_d = DIR_STOP;
  end

  assign err_d = auto_bad ||
    (illegal && state_q != S_ESTOP);

  cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .active_i (wd_active),
    .kick_i   (kick),
    .clear_i  (chg),
    .hit_o    (wd_hit),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dir_q   <= DIR_STOP;
      pend_q  <= DIR_STOP;
      ccnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      ccnt_q  <= ccnt_d;
      err_q   <= err_d;
    end
  end

  assign dir          = dir_q;
  assign manual_on    = (state_q == S_MANUAL);
  assign auto_on      = (state_q == S_AUTO);
  assign estop        = (state_q == S_ESTOP);
  assign timeout_flag = wd_expired;
  assign cmd_error    = err_q;

endmodule

// File: tb/tb_drive_command_arbiter.sv
// Scoreboard bench: DUT a (8-bit, confirm 1) and DUT b (12-bit,
// confirm 3), both with a 20-cycle watchdog.
module tb_drive_command_arbiter;

  localparam logic [1:0] MI = 2'd0;
  localparam logic [1:0] MM = 2'd1;
  localparam logic [1:0] MA = 2'd2;
  localparam logic [1:0] ME = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cva = 1'b0;
  logic [7:0]  cda = '0;
  logic        ava = 1'b0;
  logic [8:0]  ada = '0;
  logic        cvb = 1'b0;
  logic [11:0] cdb = '0;
  logic        avb = 1'b0;
  logic [8:0]  adb = '0;

  logic [8:0] dir_a, dir_b;
  logic mon_a, aon_a, es_a, to_a, er_a;
  logic mon_b, aon_b, es_b, to_b, er_b;

  drive_command_arbiter #(
    .CMD_W(8), .TIMEOUT_CYCLES(20),
    .CONFIRM_COUNT(1)
  ) dut_a (
    .clk(clk), .reset(rst),
    .cmd_valid(cva), .cmd_data(cda),
    .auto_valid(ava), .auto_dir(ada),
    .dir(dir_a), .manual_on(mon_a),
    .auto_on(aon_a), .estop(es_a),
    .timeout_flag(to_a), .cmd_error(er_a)
  );

  drive_command_arbiter #(
    .CMD_W(12), .TIMEOUT_CYCLES(20),
    .CONFIRM_COUNT(3)
  ) dut_b (
    .clk(clk), .reset(rst),
    .cmd_valid(cvb), .cmd_data(cdb),
    .auto_valid(avb), .auto_dir(adb),
    .dir(dir_b), .manual_on(mon_b),
    .auto_on(aon_b), .estop(es_b),
    .timeout_flag(to_b), .cmd_error(er_b)
  );

  typedef struct {
    int         id;
    bit         sel;
    logic [8:0] dir;
    logic [1:0] mode;
    logic       to;
    logic       err;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int step_id = 0;

  task automatic chk(string nm, int id,
                     logic [8:0] got,
                     logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d %s: got %h want %h",
               id, nm, got, want);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      logic [2:0] wm;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        wm = (e.mode == MI) ? 3'b000 :
             (3'b001 << (e.mode - 2'd1));
        if (!e.sel) begin
          chk("dir", e.id, dir_a, e.dir);
          chk("mode", e.id,
              {6'd0, es_a, aon_a, mon_a}, {6'd0, wm});
          chk("timeout", e.id, {8'd0, to_a},
              {8'd0, e.to});
          chk("cmd_error", e.id, {8'd0, er_a},
              {8'd0, e.err});
        end else begin
          chk("dir", e.id, dir_b, e.dir);
          chk("mode", e.id,
              {6'd0, es_b, aon_b, mon_b}, {6'd0, wm});
          chk("timeout", e.id, {8'd0, to_b},
              {8'd0, e.to});
          chk("cmd_error", e.id, {8'd0, er_b},
              {8'd0, e.err});
        end
      end
    end
  end

  task automatic st(bit sel, bit r, bit cv,
                    logic [11:0] cd, bit av,
                    logic [8:0] ad,
                    logic [8:0] edir,
                    logic [1:0] emode,
                    bit eto, bit eerr);
    exp_t e;
    @(negedge clk);
    rst = r;
    cva = !sel && cv;
    cda = cd[7:0];
    ava = !sel && av;
    ada = ad;
    cvb = sel && cv;
    cdb = cd;
    avb = sel && av;
    adb = ad;
    e.id   = step_id;
    e.sel  = sel;
    e.dir  = edir;
    e.mode = emode;
    e.to   = eto;
    e.err  = eerr;
    step_id++;
    q.push_back(e);
  endtask

  task automatic cmd(bit sel, logic [11:0] cd,
                     logic [8:0] edir,
                     logic [1:0] emode, bit eerr);
    st(sel, 0, 1, cd, 0, 9'h0, edir, emode, 0, eerr);
  endtask

  task automatic aut(logic [8:0] ad,
                     logic [8:0] edir, bit eerr);
    st(0, 0, 0, 12'h0, 1, ad, edir, MA, 0, eerr);
  endtask

  task automatic idl(bit sel, logic [8:0] edir,
                     logic [1:0] emode, bit eto);
    st(sel, 0, 0, 12'h0, 0, 9'h0, edir, emode, eto, 0);
  endtask

  initial begin
    st(0, 1, 0, 12'h0, 0, 9'h0, 9'h100, MI, 0, 0);
    st(0, 1, 0, 12'h0, 0, 9'h0, 9'h100, MI, 0, 0);
    cmd(0, 12'h04D, 9'h100, MM, 0);
    cmd(0, 12'h077, 9'h001, MM, 0);
    cmd(0, 12'h071, 9'h010, MM, 0);
    cmd(0, 12'h055, 9'h010, MM, 1);
    idl(0, 9'h010, MM, 0);
    cmd(0, 12'h077, 9'h001, MM, 0);
    for (int i = 0; i < 19; i++)
      idl(0, 9'h001, MM, 0);
    idl(0, 9'h100, MM, 1);
    idl(0, 9'h100, MM, 1);
    idl(0, 9'h100, MM, 1);
    cmd(0, 12'h061, 9'h002, MM, 0);
    cmd(0, 12'h078, 9'h100, MM, 0);
    cmd(0, 12'h049, 9'h100, MI, 0);
    cmd(0, 12'h077, 9'h100, MI, 0);
    cmd(0, 12'h041, 9'h100, MA, 0);
    aut(9'h008, 9'h008, 0);
    aut(9'h009, 9'h100, 1);
    aut(9'h000, 9'h100, 1);
    idl(0, 9'h100, MA, 0);
    aut(9'h100, 9'h100, 0);
    aut(9'h080, 9'h080, 0);
    cmd(0, 12'h077, 9'h080, MA, 0);
    st(0, 0, 1, 12'h04D, 1, 9'h001,
       9'h100, MM, 0, 0);
    cmd(0, 12'h041, 9'h100, MA, 0);
    aut(9'h004, 9'h004, 0);
    cmd(0, 12'h021, 9'h100, ME, 0);
    cmd(0, 12'h04D, 9'h100, ME, 0);
    cmd(0, 12'h041, 9'h100, ME, 0);
    cmd(0, 12'h077, 9'h100, ME, 0);
    cmd(0, 12'h055, 9'h100, ME, 0);
    st(0, 0, 0, 12'h0, 1, 9'h001,
       9'h100, ME, 0, 0);
    cmd(0, 12'h052, 9'h100, MI, 0);
    cmd(0, 12'h055, 9'h100, MI, 1);
    cmd(0, 12'h04D, 9'h100, MM, 0);
    cmd(0, 12'h064, 9'h008, MM, 0);
    st(0, 1, 1, 12'h077, 0, 9'h0,
       9'h100, MI, 0, 0);
    idl(0, 9'h100, MI, 0);

    st(1, 1, 0, 12'h0, 0, 9'h0, 9'h100, MI, 0, 0);
    cmd(1, 12'h04D, 9'h100, MM, 0);
    cmd(1, 12'h064, 9'h100, MM, 0);
    cmd(1, 12'h064, 9'h100, MM, 0);
    cmd(1, 12'h073, 9'h100, MM, 0);
    cmd(1, 12'h073, 9'h100, MM, 0);
    cmd(1, 12'h073, 9'h004, MM, 0);
    cmd(1, 12'h14D, 9'h004, MM, 1);
    cmd(1, 12'h073, 9'h004, MM, 0);
    cmd(1, 12'h077, 9'h004, MM, 0);
    cmd(1, 12'h04D, 9'h004, MM, 0);
    cmd(1, 12'h077, 9'h004, MM, 0);
    cmd(1, 12'h077, 9'h001, MM, 0);
    cmd(1, 12'h049, 9'h100, MI, 0);

    @(negedge clk);
    cva = 1'b0;
    ava = 1'b0;
    cvb = 1'b0;
    avb = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d want 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
